mpq_cmd_sched: RTL and testbench



---
 rtl/mpq_cmd_sched_if.sv | 24 ++
 rtl/mpq_cmd_sched.sv | 213 +++++++++++++++++++++
 tb/tb_mpq_cmd_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpq_cmd_sched_if.sv
// Requester command bus plus the engine command port of the max-priority-queue scheduler.
// master = requesters/engine side, slave = mpq_cmd_sched.
interface mpq_cmd_sched_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [5:0]  req_cmd;
   logic [15:0] req_index;
   logic [15:0] req_value;
   logic        mpq_cmd_valid;
   logic [2:0]  mpq_cmd;
   logic [7:0]  mpq_index;
   logic [7:0]  mpq_value;
   logic        mpq_busy;

   modport master (
      output req_valid, req_cmd, req_index, req_value, mpq_busy,
      input  req_ready, mpq_cmd_valid, mpq_cmd, mpq_index, mpq_value
   );

   modport slave (
      input  req_valid, req_cmd, req_index, req_value, mpq_busy,
      output req_ready, mpq_cmd_valid, mpq_cmd, mpq_index, mpq_value
   );
endinterface

// File: rtl/mpq_cmd_sched.sv
// Front-end scheduler for the max-priority-queue engine: load forwarding, heap size tracking,
// two requester FIFOs round-robined onto one engine port. MPQ_SCHED_STATS_EN adds issue/drop counters.
//
// state  | meaning
// LOAD   | forwarding initial data, waiting for the load burst to end
// IDLE   | waiting for engine idle and a queued command
// CHECK  | validating the popped command against heap_cnt
// ISSUE  | one-cycle command strobe to the engine
// ACK    | waiting for the engine to raise busy
// RUN    | waiting for the engine to drop busy
// CLOSED | WRITE issued; terminal until reset
module mpq_cmd_sched #(
   parameter int DEPTH = 4,
   parameter int MAXN  = 255
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ld_valid,
   input  logic [7:0]     ld_data,
   mpq_cmd_sched_if.slave bus,
   output logic           mpq_data_valid,
   output logic [7:0]     mpq_data,
   output logic [7:0]     heap_cnt,
   output logic           err,
   output logic           err_id,
   output logic           closed
`ifdef MPQ_SCHED_STATS_EN
   ,
   output logic [15:0]    stat_issued0,
   output logic [15:0]    stat_issued1,
   output logic [7:0]     stat_dropped
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [7:0]  MAX_CNT  = 8'(MAXN);

   localparam logic [2:0] S_LOAD   = 3'd0;
   localparam logic [2:0] S_IDLE   = 3'd1;
   localparam logic [2:0] S_CHECK  = 3'd2;
   localparam logic [2:0] S_ISSUE  = 3'd3;
   localparam logic [2:0] S_ACK    = 3'd4;
   localparam logic [2:0] S_RUN    = 3'd5;
   localparam logic [2:0] S_CLOSED = 3'd6;

   localparam logic [2:0] CMD_BUILD    = 3'd0;
   localparam logic [2:0] CMD_EXTRACT  = 3'd1;
   localparam logic [2:0] CMD_INCREASE = 3'd2;
   localparam logic [2:0] CMD_INSERT   = 3'd3;
   localparam logic [2:0] CMD_WRITE    = 3'd4;

   logic [18:0]   mem [2][DEPTH];
   logic [AW-1:0] wp [2];
   logic [AW-1:0] rp [2];
   logic [AW:0]   cnt [2];
   logic [1:0]    ne, full, push, pop, ready;
   logic [2:0]    state;
   logic          seen_ld, active, rr_ptr, sel, grant, illegal;
   logic [2:0]    iss_cmd;
   logic [7:0]    iss_idx, iss_val;
   logic          iss_id;
   logic [18:0]   head;

   always_comb begin
      ne    = '0;
      full  = '0;
      ready = '0;
      for (int r = 0; r < 2; r++) begin
         ne[r]   = (cnt[r] != '0);
         full[r] = (cnt[r] == FULL_CNT);
      end
      grant = (state == S_IDLE) && !bus.mpq_busy && (ne != 2'b00);
      sel   = ne[rr_ptr] ? rr_ptr : ~rr_ptr;
      pop   = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;
      // A full FIFO may accept while its head is popped in the same cycle.
      for (int r = 0; r < 2; r++)
         ready[r] = active && !closed && (!full[r] || pop[r]);
      push  = bus.req_valid & ready;
      head  = mem[sel][rp[sel]];
   end

   assign bus.req_ready     = ready;
   assign bus.mpq_cmd_valid = (state == S_ISSUE);

   always_comb begin
      case (iss_cmd)
         CMD_BUILD, CMD_WRITE: illegal = 1'b0;
         CMD_EXTRACT:          illegal = (heap_cnt == 8'd0);
         CMD_INCREASE:         illegal = (iss_idx >= heap_cnt);
         CMD_INSERT:           illegal = (heap_cnt == MAX_CNT);
         default:              illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      for (int r = 0; r < 2; r++)
         if (push[r])
            mem[r][wp[r]] <= {bus.req_cmd[3*r +: 3], bus.req_index[8*r +: 8], bus.req_value[8*r +: 8]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 2; r++) begin
            wp[r]  <= '0;
            rp[r]  <= '0;
            cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < 2; r++) begin
            if (closed) begin
               rp[r]  <= wp[r];
               cnt[r] <= '0;
            end else begin
               if (push[r]) wp[r] <= wp[r] + AW'(1);
               if (pop[r])  rp[r] <= rp[r] + AW'(1);
               cnt[r] <= cnt[r] + (AW+1)'(push[r]) - (AW+1)'(pop[r]);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_LOAD;
         seen_ld        <= 1'b0;
         active         <= 1'b0;
         rr_ptr         <= 1'b0;
         iss_cmd        <= '0;
         iss_idx        <= '0;
         iss_val        <= '0;
         iss_id         <= 1'b0;
         bus.mpq_cmd    <= '0;
         bus.mpq_index  <= '0;
         bus.mpq_value  <= '0;
         mpq_data_valid <= 1'b0;
         mpq_data       <= '0;
         err            <= 1'b0;
         err_id         <= 1'b0;
         closed         <= 1'b0;
      end else begin
         active         <= 1'b1;
         mpq_data_valid <= ld_valid;
         mpq_data       <= ld_data;
         err            <= 1'b0;
         case (state)
            S_LOAD: begin
               if (ld_valid)     seen_ld <= 1'b1;
               else if (seen_ld) state   <= S_IDLE;
            end
            S_IDLE: begin
               if (grant) begin
                  {iss_cmd, iss_idx, iss_val} <= head;
                  iss_id <= sel;
                  rr_ptr <= ~sel;
                  state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (illegal) begin
                  err    <= 1'b1;
                  err_id <= iss_id;
                  state  <= S_IDLE;
               end else begin
                  bus.mpq_cmd   <= iss_cmd;
                  bus.mpq_index <= iss_idx;
                  bus.mpq_value <= iss_val;
                  state         <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (iss_cmd == CMD_WRITE) begin
                  closed <= 1'b1;
                  state  <= S_CLOSED;
               end else begin
                  state  <= S_ACK;
               end
            end
            S_ACK:    if (bus.mpq_busy)  state <= S_RUN;
            S_RUN:    if (!bus.mpq_busy) state <= S_IDLE;
            S_CLOSED: state <= S_CLOSED;
            default:  state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         heap_cnt <= '0;
      end else if (state == S_ISSUE) begin
         if (iss_cmd == CMD_EXTRACT)     heap_cnt <= heap_cnt - 8'd1;
         else if (iss_cmd == CMD_INSERT) heap_cnt <= heap_cnt + 8'd1;
      end else if (ld_valid && heap_cnt != MAX_CNT) begin
         heap_cnt <= heap_cnt + 8'd1;
      end
   end

`ifdef MPQ_SCHED_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_issued0 <= '0;
         stat_issued1 <= '0;
         stat_dropped <= '0;
      end else begin
         if (state == S_ISSUE) begin
            if (iss_id && stat_issued1 != 16'hFFFF)       stat_issued1 <= stat_issued1 + 16'd1;
            else if (!iss_id && stat_issued0 != 16'hFFFF) stat_issued0 <= stat_issued0 + 16'd1;
         end
         if (state == S_CHECK && illegal && stat_dropped != 8'hFF)
            stat_dropped <= stat_dropped + 8'd1;
      end
   end
`endif
endmodule

// File: tb/tb_mpq_cmd_sched.sv
// Randomized bench for mpq_cmd_sched: queue-level scheduler model, engine responder, event scoreboard.
module tb_mpq_cmd_sched;
   localparam int DEPTH = 4;
   localparam int MAXN  = 255;

   typedef struct packed { logic [2:0] cmd; logic [7:0] idx; logic [7:0] val; } ent_t;
   typedef struct packed { logic is_err; logic id; ent_t e; } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       mpq_data_valid;
   logic [7:0] mpq_data;
   logic [7:0] heap_cnt;
   logic       err, err_id, closed;
   logic       eng_busy, hold_busy;

   mpq_cmd_sched_if bus();
   assign bus.mpq_busy = eng_busy | hold_busy;

`ifdef MPQ_SCHED_STATS_EN
   logic [15:0] stat_issued0, stat_issued1;
   logic [7:0]  stat_dropped;
`endif

   mpq_cmd_sched #(.DEPTH(DEPTH), .MAXN(MAXN)) dut (
      .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_data(ld_data), .bus(bus),
      .mpq_data_valid(mpq_data_valid), .mpq_data(mpq_data), .heap_cnt(heap_cnt),
      .err(err), .err_id(err_id), .closed(closed)
`ifdef MPQ_SCHED_STATS_EN
      , .stat_issued0(stat_issued0), .stat_issued1(stat_issued1), .stat_dropped(stat_dropped)
`endif
   );

   always #5 clk = ~clk;

   int   checks = 0, errors = 0;
   int   m_cnt;
   bit   m_ptr, m_closed;
   ent_t m_q0[$], m_q1[$];
   ev_t  exp_q[$];
   bit   eng_pending, err_prev;
   int   eng_wait, eng_hold;

   // Reference: drain both queues by round-robin, applying legality rules to a running heap size.
   function automatic void plan();
      ent_t e;
      ev_t  ev;
      bit   w, legal;
      while (m_q0.size() + m_q1.size() > 0) begin
         if (m_ptr == 1'b0) w = (m_q0.size() > 0) ? 1'b0 : 1'b1;
         else               w = (m_q1.size() > 0) ? 1'b1 : 1'b0;
         m_ptr = ~w;
         e = w ? m_q1.pop_front() : m_q0.pop_front();
         case (e.cmd)
            3'd0, 3'd4: legal = 1'b1;
            3'd1:       legal = (m_cnt > 0);
            3'd2:       legal = (int'(e.idx) < m_cnt);
            3'd3:       legal = (m_cnt < MAXN);
            default:    legal = 1'b0;
         endcase
         ev.is_err = ~legal; ev.id = w; ev.e = e;
         exp_q.push_back(ev);
         if (legal) begin
            if (e.cmd == 3'd1) m_cnt--;
            if (e.cmd == 3'd3) m_cnt++;
            if (e.cmd == 3'd4) begin
               m_closed = 1'b1;
               m_q0.delete();
               m_q1.delete();
            end
         end
      end
   endfunction

   function automatic ent_t mk(input int cmd, input int idx, input int val);
      ent_t e;
      e.cmd = 3'(cmd); e.idx = 8'(idx); e.val = 8'(val);
      return e;
   endfunction

   function automatic ent_t rand_ent();
      int r;
      r = $urandom_range(0, 9);
      return mk((r == 9) ? $urandom_range(5, 7) : r % 4, $urandom_range(0, 7), $urandom_range(0, 255));
   endfunction

   // One clock: monitor at negedge, then engine responder just after posedge.
   task automatic step();
      ev_t ev;
      @(negedge clk);
      if (bus.mpq_cmd_valid === 1'b1) begin
         checks++;
         if (eng_pending || bus.mpq_busy) begin
            errors++;
            $display("FAIL spacing: strobe with busy=%0b pending=%0b, required both 0", bus.mpq_busy, eng_pending);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected: cmd=%0d idx=%0d val=%0d, required no strobe", bus.mpq_cmd, bus.mpq_index, bus.mpq_value);
         end else begin
            ev = exp_q.pop_front();
            if (ev.is_err || bus.mpq_cmd !== ev.e.cmd || bus.mpq_index !== ev.e.idx || bus.mpq_value !== ev.e.val) begin
               errors++;
               $display("FAIL strobe_fields: got cmd=%0d idx=%0d val=%0d, required is_err=%0b id=%0d cmd=%0d idx=%0d val=%0d",
                        bus.mpq_cmd, bus.mpq_index, bus.mpq_value, ev.is_err, ev.id, ev.e.cmd, ev.e.idx, ev.e.val);
            end
         end
         eng_pending = 1'b1;
         eng_wait = $urandom_range(0, 2);
      end
      if (err === 1'b1) begin
         checks++;
         if (err_prev) begin
            errors++;
            $display("FAIL err_width: err high 2 cycles, required 1-cycle pulse");
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL err_unexpected: err_id=%0d, required no err", err_id);
         end else begin
            ev = exp_q.pop_front();
            if (!ev.is_err || err_id !== ev.id) begin
               errors++;
               $display("FAIL err_event: got err id=%0d, required is_err=%0b id=%0d cmd=%0d", err_id, ev.is_err, ev.id, ev.e.cmd);
            end
         end
      end
      err_prev = (err === 1'b1);
      @(posedge clk);
      #1;
      if (eng_pending) begin
         if (!eng_busy) begin
            if (eng_wait > 0) eng_wait--;
            else begin eng_busy = 1'b1; eng_hold = $urandom_range(0, 3); end
         end else if (eng_hold > 0) eng_hold--;
         else begin eng_busy = 1'b0; eng_pending = 1'b0; end
      end
   endtask

   task automatic push_cycle(input bit v0, input ent_t e0, input bit v1, input ent_t e1);
      logic [1:0] exp_rdy;
      exp_rdy[0] = !m_closed && (m_q0.size() < DEPTH);
      exp_rdy[1] = !m_closed && (m_q1.size() < DEPTH);
      bus.req_valid = {v1, v0};
      bus.req_cmd   = {e1.cmd, e0.cmd};
      bus.req_index = {e1.idx, e0.idx};
      bus.req_value = {e1.val, e0.val};
      #1;
      checks++;
      if (bus.req_ready !== exp_rdy) begin
         errors++;
         $display("FAIL req_ready: got %b, required %b", bus.req_ready, exp_rdy);
      end
      if (v0 && exp_rdy[0]) m_q0.push_back(e0);
      if (v1 && exp_rdy[1]) m_q1.push_back(e1);
      step();
      bus.req_valid = 2'b00;
   endtask

   task automatic drain();
      int n = 0, quiet = 0;
      while (quiet < 8 && n < 3000) begin
         step();
         n++;
         if (exp_q.size() == 0 && !eng_pending) quiet++;
         else quiet = 0;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d events outstanding, required 0", exp_q.size());
      end
      checks++;
      if (heap_cnt !== 8'(m_cnt)) begin
         errors++;
         $display("FAIL heap_cnt: got %0d, required %0d", heap_cnt, m_cnt);
      end
      checks++;
      if (closed !== m_closed) begin
         errors++;
         $display("FAIL closed: got %0b, required %0b", closed, m_closed);
      end
   endtask

   task automatic run_batch(input int n0, input int n1);
      hold_busy = 1'b1;
      for (int i = 0; i < ((n0 > n1) ? n0 : n1); i++)
         push_cycle(i < n0, rand_ent(), i < n1, rand_ent());
      hold_busy = 1'b0;
      plan();
      drain();
   endtask

   task automatic check_zero(input string name);
      logic [41:0] v;
      v = {mpq_data_valid, mpq_data, bus.mpq_cmd_valid, bus.mpq_cmd, bus.mpq_index, bus.mpq_value,
           heap_cnt, err, err_id, closed, bus.req_ready};
      checks++;
      if (v !== '0) begin
         errors++;
         $display("FAIL %s: outputs=%h, required all 0", name, v);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req_valid = 2'b00;
      ld_valid = 1'b0;
      hold_busy = 1'b0;
      eng_busy = 1'b0;
      eng_pending = 1'b0;
      err_prev = 1'b0;
      m_q0.delete(); m_q1.delete(); exp_q.delete();
      m_cnt = 0; m_ptr = 1'b0; m_closed = 1'b0;
      #2;
      check_zero("reset_values");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step();
      step();
   endtask

   task automatic load(input int n);
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1;
         ld_data = 8'($urandom);
         d = ld_data;
         step();
         if (m_cnt < MAXN) m_cnt++;
         checks++;
         if (mpq_data_valid !== 1'b1 || mpq_data !== d) begin
            errors++;
            $display("FAIL load_fwd: got v=%0b d=%h, required v=1 d=%h", mpq_data_valid, mpq_data, d);
         end
      end
      ld_valid = 1'b0;
      step();
      checks++;
      if (mpq_data_valid !== 1'b0 || heap_cnt !== 8'(m_cnt)) begin
         errors++;
         $display("FAIL load_end: got v=%0b heap_cnt=%0d, required v=0 heap_cnt=%0d", mpq_data_valid, heap_cnt, m_cnt);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.req_ready !== 2'b11 || heap_cnt !== 8'd0 || closed !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: ready=%b heap_cnt=%0d closed=%0b, required 11/0/0", bus.req_ready, heap_cnt, closed);
      end
   endtask

   task automatic test_load();
      load(5);
   endtask

   task automatic test_build();
      hold_busy = 1'b1;
      push_cycle(1'b1, mk(0, $urandom_range(0, 255), $urandom_range(0, 255)), 1'b0, mk(0, 0, 0));
      push_cycle(1'b1, mk(0, 3, 9), 1'b0, mk(0, 0, 0));
      hold_busy = 1'b0;
      plan();
      drain();
   endtask

   task automatic test_rr_extract();
      hold_busy = 1'b1;
      push_cycle(1'b1, mk(1, 0, 8'hA0), 1'b1, mk(1, 0, 8'hB0));
      push_cycle(1'b1, mk(1, 0, 8'hA1), 1'b1, mk(1, 0, 8'hB1));
      hold_busy = 1'b0;
      plan();
      drain();
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) run_batch($urandom_range(0, 4), $urandom_range(0, 4));
   endtask

   task automatic test_empty_extract();
      do_reset();
      load(1);
      hold_busy = 1'b1;
      push_cycle(1'b0, mk(0, 0, 0), 1'b1, mk(1, 0, 8'h11));
      push_cycle(1'b0, mk(0, 0, 0), 1'b1, mk(1, 0, 8'h22));
      hold_busy = 1'b0;
      plan();
      drain();
   endtask

   task automatic test_full();
      do_reset();
      load(260);
      hold_busy = 1'b1;
      push_cycle(1'b1, mk(3, 0, 8'h10), 1'b1, mk(2, 254, 8'hFF));
      push_cycle(1'b0, mk(0, 0, 0), 1'b1, mk(2, 255, 8'h01));
      hold_busy = 1'b0;
      plan();
      drain();
   endtask

   task automatic test_fifo_full();
      hold_busy = 1'b1;
      for (int i = 0; i < 5; i++) push_cycle(1'b1, rand_ent(), i == 2, rand_ent());
      hold_busy = 1'b0;
      plan();
      drain();
   endtask

   task automatic test_write();
      hold_busy = 1'b1;
      push_cycle(1'b1, mk(4, 1, 2), 1'b0, mk(0, 0, 0));
      push_cycle(1'b1, mk(0, 5, 6), 1'b0, mk(0, 0, 0));
      hold_busy = 1'b0;
      plan();
      drain();
      push_cycle(1'b0, mk(0, 0, 0), 1'b1, mk(1, 0, 0));
      for (int i = 0; i < 30; i++) step();
   endtask

   task automatic test_reset_mid_run();
      int n = 0;
      do_reset();
      load(5);
      hold_busy = 1'b1;
      push_cycle(1'b1, mk(2, 2, 8'h5A), 1'b0, mk(0, 0, 0));
      hold_busy = 1'b0;
      plan();
      while (!eng_busy && n < 50) begin step(); n++; end
      checks++;
      if (!eng_busy) begin
         errors++;
         $display("FAIL run_timeout: engine never started, required start within 50 cycles");
      end
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      do_reset();
   endtask

   initial begin
      rst_n = 1'b1;
      ld_valid = 1'b0;
      ld_data = 8'd0;
      eng_busy = 1'b0;
      hold_busy = 1'b0;
      bus.req_valid = 2'b00;
      bus.req_cmd = '0;
      bus.req_index = '0;
      bus.req_value = '0;
      #1;
      test_reset();
      test_load();
      test_build();
      test_rr_extract();
      test_random();
      test_fifo_full();
      test_empty_extract();
      test_full();
      test_write();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
